// File: rtl/mor1kx_irq_sync_pkg.sv
// Shared limits and helpers for the interrupt-line conditioning block.
package mor1kx_irq_sync_pkg;

  localparam int OR1K_IRQ_SYNC_MAX_STAGES = 4;
  localparam int OR1K_IRQ_FILTER_MAX      = 15;
  localparam int OR1K_IRQ_MAX_LINES       = 32;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // A counter needs at least one bit even when no filtering is requested.
  function automatic int cnt_width(input int filter_cycles);
    return (clog2(filter_cycles) < 1) ? 1 : clog2(filter_cycles);
  endfunction

endpackage

// File: rtl/mor1kx_irq_sync_filter.sv
// One interrupt line: synchroniser, polarity normalisation, stability filter
// and rising-edge pulse.
module mor1kx_irq_filter
  import mor1kx_irq_sync_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_raw_i,
  output logic irq_o,
  output logic irq_rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   flip;

  // Synchroniser resets to the idle raw level so release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw_i};
  end

  assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  if (FILTER_CYCLES == 1) begin : g_nofilt
    assign flip = (s != irq_o);
  end else begin : g_filt
    localparam int             CNT_W    = cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;

    assign flip = (s != irq_o) && (cnt_q == CNT_LAST);

    // Count consecutive cycles disagreeing with the output; any agreement clears it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     cnt_q <= '0;
      else if ((s == irq_o) || flip)  cnt_q <= '0;
      else                            cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Accept the synced level once stable; pulse only on a 0->1 acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_o      <= 1'b0;
      irq_rise_o <= 1'b0;
    end else begin
      if (flip) irq_o <= s;
      irq_rise_o <= flip & s;
    end
  end

endmodule

// File: rtl/mor1kx_irq_sync.sv
// Conditions raw external interrupt lines before they reach the PIC irq_i bus.
module mor1kx_irq_sync
  import mor1kx_irq_sync_pkg::*;
#(
  parameter int          NUM_IRQ        = 32,
  parameter int          SYNC_STAGES    = 2,
  parameter int          FILTER_CYCLES  = 4,
  parameter logic [31:0] IRQ_ACTIVE_LOW = 32'h0000_0000,
  parameter logic [31:0] LINE_EN        = 32'hffff_ffff
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_raw_i,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic [NUM_IRQ-1:0] irq_rise_o
);

  if (NUM_IRQ < 1 || NUM_IRQ > OR1K_IRQ_MAX_LINES) begin : g_bad_num
    $fatal(1, "mor1kx_irq_sync: NUM_IRQ must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > OR1K_IRQ_SYNC_MAX_STAGES) begin : g_bad_sync
    $fatal(1, "mor1kx_irq_sync: SYNC_STAGES must be 2..4");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > OR1K_IRQ_FILTER_MAX) begin : g_bad_filt
    $fatal(1, "mor1kx_irq_sync: FILTER_CYCLES must be 1..15");
  end

  // Lines are independent; unimplemented lines are tied off with no flops.
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    if (LINE_EN[i]) begin : g_on
      mor1kx_irq_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES),
        .ACTIVE_LOW   (IRQ_ACTIVE_LOW[i])
      ) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_raw_i (irq_raw_i[i]),
        .irq_o     (irq_o[i]),
        .irq_rise_o(irq_rise_o[i])
      );
    end else begin : g_off
      assign irq_o[i]      = 1'b0;
      assign irq_rise_o[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_mor1kx_irq_sync.sv
// Bench for mor1kx_irq_sync: three configurations share one stimulus stream and
// are checked every cycle against a window-based model, plus directed checks.
module tb_mor1kx_irq_sync;

  localparam int          SYNC[3] = '{2, 2, 2};
  localparam int          FILT[3] = '{4, 4, 1};
  localparam logic [31:0] ACT[3]  = '{32'h0, 32'h1, 32'h0};
  localparam logic [31:0] LEN[3]  = '{32'hffffffff, 32'h0000ffff, 32'hffffffff};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq_raw = '1;
  logic [31:0] irq_a, rise_a, irq_b, rise_b, irq_c, rise_c;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mor1kx_irq_sync #(.NUM_IRQ(32), .SYNC_STAGES(2), .FILTER_CYCLES(4),
                    .IRQ_ACTIVE_LOW(32'h0), .LINE_EN(32'hffffffff)) dut_a (
    .clk(clk), .rst_n(rst_n), .irq_raw_i(irq_raw), .irq_o(irq_a), .irq_rise_o(rise_a));

  mor1kx_irq_sync #(.NUM_IRQ(32), .SYNC_STAGES(2), .FILTER_CYCLES(4),
                    .IRQ_ACTIVE_LOW(32'h1), .LINE_EN(32'h0000ffff)) dut_b (
    .clk(clk), .rst_n(rst_n), .irq_raw_i(irq_raw), .irq_o(irq_b), .irq_rise_o(rise_b));

  mor1kx_irq_sync #(.NUM_IRQ(32), .SYNC_STAGES(2), .FILTER_CYCLES(1),
                    .IRQ_ACTIVE_LOW(32'h0), .LINE_EN(32'hffffffff)) dut_c (
    .clk(clk), .rst_n(rst_n), .irq_raw_i(irq_raw), .irq_o(irq_c), .irq_rise_o(rise_c));

  // Model: raw samples travel through a plain delay line; a line's output
  // flips when the last FILT synced samples all disagree with it.
  logic [31:0] pipe_m[3][4];
  logic [31:0] win_m[3][16];
  logic [31:0] out_m[3];
  logic [31:0] rise_m[3];

  function automatic logic [31:0] synced(input int c);
    return pipe_m[c][SYNC[c]-1] ^ ACT[c];
  endfunction

  function automatic logic [31:0] next_out(input int c, input logic [31:0] s);
    logic [31:0] n;
    int          disagree;
    n = out_m[c];
    for (int b = 0; b < 32; b++) begin
      disagree = (s[b] != out_m[c][b]) ? 1 : 0;
      for (int j = 0; j < FILT[c] - 1; j++)
        if (win_m[c][j][b] != out_m[c][b]) disagree++;
      if (disagree == FILT[c]) n[b] = ~out_m[c][b];
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        for (int j = 0; j < 4; j++) pipe_m[c][j] <= ACT[c];
        for (int j = 0; j < 16; j++) win_m[c][j] <= '0;
        out_m[c]  <= '0;
        rise_m[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        out_m[c]  <= next_out(c, synced(c)) & LEN[c];
        rise_m[c] <= next_out(c, synced(c)) & ~out_m[c] & LEN[c];
        pipe_m[c][0] <= irq_raw;
        for (int j = 1; j < 4; j++) pipe_m[c][j] <= pipe_m[c][j-1];
        win_m[c][0] <= synced(c);
        for (int j = 1; j < 16; j++) win_m[c][j] <= win_m[c][j-1];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_irq_a",  irq_a,  out_m[0]);
    chk("model_rise_a", rise_a, rise_m[0]);
    chk("model_irq_b",  irq_b,  out_m[1]);
    chk("model_rise_b", rise_b, rise_m[1]);
    chk("model_irq_c",  irq_c,  out_m[2]);
    chk("model_rise_c", rise_c, rise_m[2]);
  end

  // Advance n edges and land 3 time units after the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  // Watch 14 edges: first edge index where line b of dut d reads val (-1 if
  // never), number of rise pulses seen, and the rise word on that edge.
  task automatic measure(input int d, input int b, input logic val,
                         output int lat, output int rises, output logic [31:0] rise_at);
    logic [31:0] lv, rv;
    lat = -1;
    rises = 0;
    rise_at = '0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      case (d)
        0:       begin lv = irq_a; rv = rise_a; end
        1:       begin lv = irq_b; rv = rise_b; end
        default: begin lv = irq_c; rv = rise_c; end
      endcase
      if (lat < 0 && lv[b] == val) begin
        lat = k;
        rise_at = rv;
      end
      if (rv[b]) rises++;
    end
    #2;
  endtask

  int          lat, rises;
  logic [31:0] rise_at;

  initial begin
    // Reset with every line asserted, then release.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #3;
      chk("rst_irq", irq_a, 32'h0);
      chk("rst_rise", rise_a, 32'h0);
    end
    rst_n = 1'b1;
    measure(0, 0, 1'b1, lat, rises, rise_at);
    chk_int("rst_release_latency", lat, 6);
    chk("rst_release_rise_all", rise_at, 32'hffffffff);
    chk_int("rst_release_rise_count", rises, 1);
    chk("rst_release_level", irq_a, 32'hffffffff);

    // Glitch rejection on line 5.
    irq_raw = '0;
    cyc(10);
    chk("idle_level", irq_a, 32'h0);
    irq_raw[5] = 1'b1;
    cyc(3);
    irq_raw[5] = 1'b0;
    measure(0, 5, 1'b1, lat, rises, rise_at);
    chk_int("glitch3_level", lat, -1);
    chk_int("glitch3_rise", rises, 0);
    irq_raw[5] = 1'b1;
    measure(0, 5, 1'b1, lat, rises, rise_at);
    chk_int("assert_latency", lat, 6);
    chk_int("assert_rise_count", rises, 1);

    // Deassert and dip tolerance on line 7.
    irq_raw[7] = 1'b1;
    cyc(10);
    chk("line7_high", irq_a & 32'h80, 32'h80);
    irq_raw[7] = 1'b0;
    cyc(2);
    irq_raw[7] = 1'b1;
    measure(0, 7, 1'b0, lat, rises, rise_at);
    chk_int("dip2_level", lat, -1);
    irq_raw[7] = 1'b0;
    measure(0, 7, 1'b0, lat, rises, rise_at);
    chk_int("deassert_latency", lat, 6);
    chk_int("deassert_no_rise", rises, 0);

    // Active-low line 0 on dut_b.
    irq_raw[0] = 1'b1;
    cyc(10);
    chk("pol_idle", irq_b & 32'h1, 32'h0);
    irq_raw[0] = 1'b0;
    measure(1, 0, 1'b1, lat, rises, rise_at);
    chk_int("pol_assert_latency", lat, 6);

    // No filtering on dut_c.
    irq_raw[9] = 1'b1;
    measure(2, 9, 1'b1, lat, rises, rise_at);
    chk_int("nofilt_latency", lat, 3);
    irq_raw[10] = 1'b1;
    cyc(1);
    irq_raw[10] = 1'b0;
    measure(2, 10, 1'b1, lat, rises, rise_at);
    chk_int("nofilt_pulse_latency", lat, 2);
    chk_int("nofilt_pulse_rise", rises, 1);

    // Disabled upper lines on dut_b stay low for any input.
    for (int k = 0; k < 40; k++) begin
      irq_raw = $urandom();
      cyc(1);
      chk("line_en_irq", irq_b & 32'hffff0000, 32'h0);
      chk("line_en_rise", rise_b & 32'hffff0000, 32'h0);
    end

    // Reset in the middle of a filter window on line 3.
    irq_raw = '0;
    cyc(10);
    irq_raw[3] = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    cyc(2);
    chk("midrst_level", irq_a & 32'h8, 32'h0);
    rst_n = 1'b1;
    measure(0, 3, 1'b1, lat, rises, rise_at);
    chk_int("midrst_latency", lat, 6);
    chk_int("midrst_rise_count", rises, 1);

    // Random traffic with varied hold times and occasional resets.
    for (int k = 0; k < 300; k++) begin
      irq_raw = irq_raw ^ ($urandom() & $urandom());
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        cyc($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      cyc($urandom_range(1, 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
